// File: rtl/function_chooser_pkg.sv
// Shared types and constants for the function chooser request issuer.
package function_chooser_pkg;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned ERR_W = 2;

  typedef enum logic [2:0] {
    INIT_CLR = 3'd0,
    IDLE     = 3'd1,
    REQ      = 3'd2,
    WAIT_FIN = 3'd3,
    CLEAR    = 3'd4,
    WAIT_CLR = 3'd5,
    DONE     = 3'd6
  } state_e;

  localparam logic [ERR_W-1:0] ERR_NONE        = 2'd0;
  localparam logic [ERR_W-1:0] ERR_BAD_IDX     = 2'd1;
  localparam logic [ERR_W-1:0] ERR_FIN_TIMEOUT = 2'd2;
  localparam logic [ERR_W-1:0] ERR_CLR_TIMEOUT = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level, reset value 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: shift the input through two stages
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer stages with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/function_request_issuer.sv
// Clocked initiator for the self-timed one-hot function chooser: issues a
// request pulse, waits for fin, clears the chooser, waits for fin to drop.
module function_request_issuer
  import function_chooser_pkg::*;
#(
  parameter int unsigned N        = 2,
  parameter int unsigned IDX_W    = (N > 1) ? $clog2(N) : 1,
  parameter int unsigned REQ_HOLD = 2,
  parameter int unsigned CLR_HOLD = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  input  logic [IDX_W-1:0] cmd_idx,
  output logic             cmd_ready,
  output logic [N-1:0]     reqs,
  output logic             chs_rst,
  input  logic             fin,
  output logic             done,
  output logic [IDX_W-1:0] done_idx,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam logic [CNT_W-1:0] REQ_HOLD_C = CNT_W'(REQ_HOLD);
  localparam logic [CNT_W-1:0] CLR_HOLD_C = CNT_W'(CLR_HOLD);
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               job_ok_q, job_ok_d;
  logic [N-1:0]       reqs_q, reqs_d;
  logic               chs_rst_q, chs_rst_d;
  logic               cmd_ready_q, cmd_ready_d;
  logic               done_q, done_d;
  logic [IDX_W-1:0]   done_idx_q, done_idx_d;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   err_code_q, err_code_d;
  logic               fin_s;

  sync_2ff u_fin_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (fin),
    .q     (fin_s)
  );

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and next-output logic; outputs are registered from these values
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    job_ok_d   = job_ok_q;
    reqs_d     = '0;
    chs_rst_d  = 1'b0;
    done_d     = 1'b0;
    done_idx_d = done_idx_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      INIT_CLR, CLEAR: begin
        // Counter starts at 0 after reset, at 1 when entering from WAIT_FIN
        // (the entry edge already drove the first clear cycle)
        if (cnt_q < CLR_HOLD_C) begin
          chs_rst_d = 1'b1;
          cnt_d     = cnt_inc;
        end else begin
          state_d = WAIT_CLR;
          cnt_d   = '0;
        end
      end

      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (32'(cmd_idx) >= N) begin
            err_d      = 1'b1;
            err_code_d = ERR_BAD_IDX;
          end else begin
            idx_d           = cmd_idx;
            job_ok_d        = 1'b1;
            reqs_d[cmd_idx] = 1'b1;
            cnt_d           = CNT_W'(1);
            state_d         = REQ;
          end
        end
      end

      REQ: begin
        // Line returns low afterwards so the chooser sees a fresh posedge next time
        if (cnt_q < REQ_HOLD_C) begin
          reqs_d[idx_q] = 1'b1;
          cnt_d         = cnt_inc;
        end else begin
          state_d = WAIT_FIN;
          cnt_d   = '0;
        end
      end

      WAIT_FIN: begin
        if (fin_s) begin
          state_d   = CLEAR;
          chs_rst_d = 1'b1;
          cnt_d     = CNT_W'(1);
        end else if (cnt_inc == TIMEOUT_C) begin
          // Still clear the chooser as a recovery attempt, but report no done
          err_d      = 1'b1;
          err_code_d = ERR_FIN_TIMEOUT;
          job_ok_d   = 1'b0;
          state_d    = CLEAR;
          chs_rst_d  = 1'b1;
          cnt_d      = CNT_W'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end

      WAIT_CLR: begin
        if (!fin_s) begin
          if (job_ok_q) begin
            state_d    = DONE;
            done_d     = 1'b1;
            done_idx_d = idx_q;
          end else begin
            state_d = IDLE;
          end
          job_ok_d = 1'b0;
          cnt_d    = '0;
        end else if (cnt_inc == TIMEOUT_C) begin
          err_d      = 1'b1;
          err_code_d = ERR_CLR_TIMEOUT;
          job_ok_d   = 1'b0;
          state_d    = IDLE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = INIT_CLR;
        cnt_d   = '0;
      end
    endcase

    // Withhold ready while the chooser still reports fin
    cmd_ready_d = (state_d == IDLE) && !fin_s;
  end

  // State, counter and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT_CLR;
      cnt_q       <= '0;
      idx_q       <= '0;
      job_ok_q    <= 1'b0;
      reqs_q      <= '0;
      chs_rst_q   <= 1'b0;
      cmd_ready_q <= 1'b0;
      done_q      <= 1'b0;
      done_idx_q  <= '0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      job_ok_q    <= job_ok_d;
      reqs_q      <= reqs_d;
      chs_rst_q   <= chs_rst_d;
      cmd_ready_q <= cmd_ready_d;
      done_q      <= done_d;
      done_idx_q  <= done_idx_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign reqs      = reqs_q;
  assign chs_rst   = chs_rst_q;
  assign done      = done_q;
  assign done_idx  = done_idx_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule
